// File: rtl/dig_ota_array.sv
// Multi-channel clocked digital OTA: synchronised differential inputs with
// common-mode keeper and persistence filter, plus a high-time measurement FSM.
module dig_ota_array #(
    parameter int CH     = 4,
    parameter int SYNC   = 2,
    parameter int FILT_W = 3,
    parameter int WIN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [CH-1:0]           vip,
    input  logic [CH-1:0]           vin,
    input  logic [FILT_W-1:0]       filt_len,
    input  logic                    start,
    input  logic [$clog2(CH)-1:0]   ch_sel,
    output logic [CH-1:0]           out,
    output logic [CH-1:0]           cm,
    output logic                    busy,
    output logic                    done,
    output logic [WIN_W:0]          count
);

    localparam int SEL_W = $clog2(CH);
    localparam logic [WIN_W-1:0] WIN_LAST = {WIN_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers (free-running, independent of en)
    // ------------------------------------------------------------------
    logic [CH-1:0] syn_p_q [SYNC];
    logic [CH-1:0] syn_n_q [SYNC];
    logic [CH-1:0] sp;
    logic [CH-1:0] sn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) begin
                syn_p_q[i] <= '0;
                syn_n_q[i] <= '0;
            end
        end else begin
            syn_p_q[0] <= vip;
            syn_n_q[0] <= vin;
            for (int i = 1; i < SYNC; i++) begin
                syn_p_q[i] <= syn_p_q[i-1];
                syn_n_q[i] <= syn_n_q[i-1];
            end
        end
    end

    assign sp = syn_p_q[SYNC-1];
    assign sn = syn_n_q[SYNC-1];

    // ------------------------------------------------------------------
    // Per-channel decision with persistence filter
    // ------------------------------------------------------------------
    logic [CH-1:0] out_vec;
    logic [CH-1:0] cm_vec;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic              out_q;
        logic              out_d;
        logic              cm_q;
        logic              cm_d;
        logic [FILT_W-1:0] cnt_q;
        logic [FILT_W-1:0] cnt_d;
        logic              diff;
        logic              mismatch;

        assign diff     = sp[gi] ^ sn[gi];
        assign mismatch = diff & (sp[gi] != out_q);

        // cnt never exceeds filt_len, so it cannot wrap.
        always_comb begin
            out_d = out_q;
            cm_d  = cm_q;
            cnt_d = cnt_q;
            if (!en) begin
                cnt_d = '0;
            end else begin
                cm_d = ~diff;
                if (!mismatch) begin
                    cnt_d = '0;
                end else if (cnt_q >= filt_len) begin
                    out_d = sp[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= 1'b0;
                cm_q  <= 1'b0;
                cnt_q <= '0;
            end else begin
                out_q <= out_d;
                cm_q  <= cm_d;
                cnt_q <= cnt_d;
            end
        end

        assign out_vec[gi] = out_q;
        assign cm_vec[gi]  = cm_q;
    end

    assign out = out_vec;
    assign cm  = cm_vec;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic [WIN_W:0]   acc_q;
    logic [WIN_W:0]   acc_d;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic [WIN_W:0]   count_q;
    logic [WIN_W:0]   count_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        win_d   = win_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start && en) begin
                    state_d = RUN;
                    sel_d   = ch_sel;
                    acc_d   = '0;
                    win_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    // Samples the pre-edge decision of the latched channel.
                    acc_d = acc_q + {{WIN_W{1'b0}}, out_vec[sel_q]};
                    win_d = win_q + 1'b1;
                    if (win_q == WIN_LAST) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                count_d = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            acc_q   <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            win_q   <= win_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_dig_ota_array.sv
// Scoreboard bench for dig_ota_array: expected out changes and measurement
// results are queued with their expected edge; a monitor pops and compares.
module tb_dig_ota_array;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] vip;
    logic [3:0] vin;
    logic [2:0] filt_len;
    logic       start;
    logic [1:0] ch_sel;
    logic [3:0] out;
    logic [3:0] cm;
    logic       busy;
    logic       done;
    logic [8:0] count;

    dig_ota_array #(.CH(4), .SYNC(2), .FILT_W(3), .WIN_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .vip      (vip),
        .vin      (vin),
        .filt_len (filt_len),
        .start    (start),
        .ch_sel   (ch_sel),
        .out      (out),
        .cm       (cm),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t oq[$];
    exp_t dq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic mon_en = 1'b0;
    logic [3:0] prev_out = 4'd0;
    logic [3:0] exp_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_out(input int c, input int v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        oq.push_back(e);
    endtask

    task automatic push_done(input int c, input int v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        dq.push_back(e);
    endtask

    // Monitor: every out change and every done pulse must match a queued entry.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (out !== prev_out) begin
                if (oq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got %0d at cyc %0d, none expected", out, cyc);
                end else begin
                    e = oq.pop_front();
                    check("out_val", int'(out), e.val);
                    check("out_cyc", cyc, e.cyc);
                    $display("out event: cyc=%0d out=%b", cyc, out);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: count=%0d at cyc %0d, none expected", count, cyc);
                end else begin
                    e = dq.pop_front();
                    check("done_count", int'(count), e.val);
                    check("done_cyc", cyc, e.cyc);
                    $display("done event: cyc=%0d count=%0d", cyc, count);
                end
            end
        end
        prev_out = out;
    end

    initial begin
        int t;
        rst_n    = 1'b0;
        en       = 1'b0;
        vip      = 4'b0000;
        vin      = 4'b0000;
        filt_len = 3'd0;
        start    = 1'b0;
        ch_sel   = 2'd0;
        tick(2);
        check("rst_out",   int'(out),   0);
        check("rst_cm",    int'(cm),    0);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);
        check("rst_count", int'(count), 0);

        rst_n = 1'b1;
        en    = 1'b1;
        tick(4);
        check("cm_idle", int'(cm), 15);
        check("out_idle", int'(out), 0);
        mon_en = 1'b1;

        // Latency, L=0, channel 0
        t = cyc;
        vip = 4'b0001; vin = 4'b1110;
        exp_out = 4'b0001;
        push_out(t + 3, exp_out);
        tick(2);
        check("cm_before_edge3", int'(cm), 15);
        tick(1);
        check("cm_edge3", int'(cm), 0);
        tick(3);

        // Latency, L=3, channel 1
        filt_len = 3'd3;
        t = cyc;
        vip = 4'b0011; vin = 4'b1100;
        exp_out = 4'b0011;
        push_out(t + 6, exp_out);
        tick(8);

        // Common-mode hold on channel 1, then release to 0
        vin = 4'b1110;
        tick(50);
        check("cm_hold_out", int'(out), 3);
        check("cm_hold_cm",  int'(cm),  2);
        t = cyc;
        vip = 4'b0001; vin = 4'b1110;
        exp_out = 4'b0001;
        push_out(t + 6, exp_out);
        tick(8);

        // Glitch filter L=2 on channel 2: 2-cycle pulse rejected, 3-cycle passes
        filt_len = 3'd2;
        tick(1);
        vip = 4'b0101; vin = 4'b1010;
        tick(2);
        vip = 4'b0001; vin = 4'b1010;
        tick(8);
        check("glitch2_out", int'(out), 1);
        t = cyc;
        vip = 4'b0101; vin = 4'b1010;
        exp_out = 4'b0101;
        push_out(t + 5, exp_out);
        tick(3);
        vip = 4'b0001; vin = 4'b1010;
        tick(6);

        // Channel 3 high, L=0
        filt_len = 3'd0;
        tick(1);
        t = cyc;
        vip = 4'b1001; vin = 4'b0010;
        exp_out = 4'b1101;
        push_out(t + 3, exp_out);
        tick(5);

        // Full-window measurement; ch_sel change and start while busy ignored
        ch_sel = 2'd3;
        t = cyc;
        start = 1'b1;
        push_done(t + 258, 256);
        tick(1);
        start  = 1'b0;
        ch_sel = 2'd1;
        check("busy_after_start", int'(busy), 1);
        tick(48);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(207);
        check("busy_before_done", int'(busy), 1);
        tick(1);
        check("busy_at_done", int'(busy), 0);
        tick(4);

        // 50% square wave on channel 3, period 128 -> count 128
        for (int i = 0; i < 384; i++) begin
            if (i % 64 == 0) begin
                vip[3] = ~vip[3];
                vin[3] = ~vin[3];
                exp_out[3] = ~exp_out[3];
                push_out(cyc + 3, int'(exp_out));
            end
            if (i == 70) begin
                start  = 1'b1;
                ch_sel = 2'd3;
                push_done(cyc + 258, 128);
            end else begin
                start = 1'b0;
            end
            tick(1);
        end
        tick(4);

        // Abort with en=0 after 100 RUN cycles: no done, count retained
        ch_sel = 2'd3;
        start  = 1'b1;
        tick(1);
        start = 1'b0;
        tick(100);
        en = 1'b0;
        tick(1);
        check("abort_busy",  int'(busy),  0);
        check("abort_count", int'(count), 128);
        tick(300);
        check("abort_count_hold", int'(count), 128);
        en = 1'b1;
        tick(2);

        // Async reset mid-RUN with all outputs high
        t = cyc;
        vip = 4'b1111; vin = 4'b0000;
        exp_out = 4'b1111;
        push_out(t + 3, int'(exp_out));
        tick(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(50);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_out",  int'(out),  15);
        mon_en = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out",   int'(out),   0);
        check("async_rst_cm",    int'(cm),    0);
        check("async_rst_busy",  int'(busy),  0);
        check("async_rst_done",  int'(done),  0);
        check("async_rst_count", int'(count), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_busy",  int'(busy),  0);
        check("post_rst_count", int'(count), 0);

        check("out_queue_left",  oq.size(), 0);
        check("done_queue_left", dq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dig_ota_array.md
# dig_ota_array

Multi-channel clocked successor to the single-pair digital OTA: each of CH channels samples a differential 1-bit input pair (vip/vin) through a synchroniser, resolves a decision only when the pair is differential, and holds its last decision while the pair is in common mode. A programmable persistence filter rejects short glitches. A shared measurement FSM counts the high-time of one selected channel output over a fixed window, for offset and duty characterisation. The block sits between the analog-facing pad inputs and the digital control logic of the tile.

## Interface
- CH, default 4: channel count, ≥2, power of two.
- SYNC, default 2: synchroniser depth, ≥2.
- FILT_W, default 3: width of filt_len.
- WIN_W, default 8: measurement window is 2^WIN_W cycles.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable.
- vip  in  CH  positive inputs, asynchronous.
- vin  in  CH  negative inputs, asynchronous.
- filt_len  in  FILT_W  persistence length L (quasi-static).
- start  in  1  measurement start pulse.
- ch_sel  in  $clog2(CH)  channel to measure.
- out  out  CH  registered decision per channel.
- cm  out  CH  registered common-mode flag per channel.
- busy  out  1  measurement in progress.
- done  out  1  one-cycle pulse, count valid.
- count  out  WIN_W+1  number of cycles out[sel] was 1 in the last window.

## Operation
- Reset (rst_n=0, async): synchroniser flops, out, cm, per-channel counters, busy, done, count, and FSM state all go to 0. FSM goes to IDLE.
- Synchroniser: SYNC flops per input bit; sp/sn are the last-stage values. Runs regardless of en.
- Per channel, each cycle with en=1:
  - diff = sp ^ sn; cm <= ~diff.
  - mismatch = diff & (sp != out).
  - If mismatch=0: cnt <= 0, out holds. This covers common mode, which acts as the keeper.
  - If mismatch=1 and cnt ≥ L: out <= sp, cnt <= 0.
  - If mismatch=1 and cnt < L: cnt <= cnt+1.
  - cnt is FILT_W bits and saturates by construction.
- en=0: out, cm, and count hold. Per-channel cnt clears. A RUN measurement aborts to IDLE with no done pulse.
- Measurement FSM:
  - IDLE: on start=1 and en=1, latch ch_sel, clear acc and the window counter, go to RUN, busy=1.
  - RUN: each cycle, acc += out[sel_latched]. After exactly 2^WIN_W RUN cycles, go to DONE.
  - DONE (one cycle): count <= acc, done=1, busy=0, then IDLE.
  - start while busy is ignored. A new start is accepted in IDLE on the cycle after DONE.
- acc and count are WIN_W+1 bits, so the full value 2^WIN_W is representable.
- count holds its last result until the next DONE.

## Timing
- Pin-to-out latency: with edge 1 defined as the first edge that samples the new pin value, out changes on edge SYNC+L+1. For SYNC=2 and L=0, that is edge 3.
- cm latency: changes on edge SYNC+1.
- Glitch rejection: a differential pulse lasting ≤L synchronised cycles never changes out.
- start sampled on edge e (in IDLE): busy=1 after e.
  - RUN samples out[sel] on edges e+1 … e+2^WIN_W.
  - done=1 and count are valid after edge e+2^WIN_W+1, for one cycle.
- Sample-vs-update ordering: a change of out on the same edge as a RUN sample counts the pre-edge value.
- Async reset mid-RUN: immediate return to IDLE with count=0. No done pulse.

## Test plan
- Reset: assert rst_n=0 mid-RUN with out=4'b1111 -> all outputs read 0 immediately; after release, busy=0 and count=0.
- Latency: SYNC=2, L=0, ch0 vip=1/vin=0 -> out[0] rises on edge 3 and cm[0]=0 from edge 3. With L=3 -> out[0] rises on edge 6.
- Common-mode hold: set out[1]=1, then drive vip=vin=1 for 50 cycles -> out[1] stays 1 and cm[1]=1. Then drive vip=0/vin=1 -> out[1] falls after SYNC+L+1 edges.
- Glitch filter: L=2, out[2]=0, 2-cycle pulse vip=1/vin=0 -> out[2] stays 0. A 3-cycle pulse -> out[2] becomes 1.
- Measurement:
  - WIN_W=8, ch_sel=3, out[3] held 1 throughout -> done after 258 edges with count=256.
  - Input toggled every 64 cycles, aligned to the window -> count=128.
  - ch_sel changed during RUN is ignored.
- Abort and start rules:
  - en=0 at cycle 100 of RUN -> busy=0, no done, previous count retained.
  - start pulsed while busy -> no restart; done occurs at the original time.
